// File: rtl/cpu_top.sv
// Boot front end: UART 8N1 receiver, little-endian word loader into IMEM,
// idle-timeout hand-off to RUN with an `indication` status flag.
module cpu_top #(
  parameter int unsigned CLK_FREQ_HZ       = 40_000_000,
  parameter int unsigned BAUD              = 115_200,
  parameter int unsigned CLKS_PER_BIT      = CLK_FREQ_HZ / BAUD,
  parameter int unsigned IMEM_DEPTH        = 1024,
  parameter int unsigned IDLE_TIMEOUT_BITS = 20
) (
  input  logic                          clk,
  input  logic                          reset_n,     // active-high synchronous reset
  input  logic                          io_rx,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_raddr,
  output logic [31:0]                   imem_rdata,
  output logic                          indication
);

  localparam int unsigned AW      = $clog2(IMEM_DEPTH);
  localparam int unsigned WCW     = AW + 1;
  localparam int unsigned CW      = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF    = CLKS_PER_BIT / 2;
  localparam int unsigned TIMEOUT = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned IW      = $clog2(TIMEOUT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {LD_LOAD, LD_RUN} ld_state_t;

  // Synchronizer
  logic            rx_meta_q, rx_s_q;

  // Receiver
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;

  // Loader
  ld_state_t       ld_state_q, ld_state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [AW-1:0]   word_addr_q, word_addr_d;
  logic [WCW-1:0]  word_count_q, word_count_d;
  logic [31:0]     word_buf_q, word_buf_d;
  logic            got_byte_q, got_byte_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
  logic            indication_q, indication_d;

  // IMEM write port
  logic            mem_we_c;
  logic [AW-1:0]   mem_waddr_c;
  logic [31:0]     mem_wdata_c;
  logic [31:0]     lane_word_c;

  logic [31:0]     imem_q [IMEM_DEPTH];
  logic [31:0]     imem_rdata_q;

  // UART frame decoder: start-bit qualification, centre sampling, stop check
  always_comb begin
    rx_state_d   = rx_state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          rx_state_d = RX_START;
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
        end
      end
      RX_START: begin
        if (clk_cnt_q == CW'(HALF - 1)) begin
          clk_cnt_d  = '0;
          rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_cnt_d  = bit_cnt_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d    = '0;
          byte_valid_d = rx_s_q;
          rx_state_d   = RX_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Byte packer, overflow guard and idle timeout into RUN
  always_comb begin
    ld_state_d   = ld_state_q;
    byte_cnt_d   = byte_cnt_q;
    word_addr_d  = word_addr_q;
    word_count_d = word_count_q;
    word_buf_d   = word_buf_q;
    got_byte_d   = got_byte_q;
    idle_cnt_d   = idle_cnt_q;
    indication_d = (ld_state_q == LD_RUN);
    mem_we_c     = 1'b0;
    mem_waddr_c  = word_addr_q;
    mem_wdata_c  = word_buf_q;
    lane_word_c  = word_buf_q;
    lane_word_c[{byte_cnt_q, 3'b000} +: 8] = shift_q;
    if (ld_state_q == LD_LOAD) begin
      if (byte_valid_q) begin
        idle_cnt_d = '0;
        got_byte_d = 1'b1;
        if (word_count_q < WCW'(IMEM_DEPTH)) begin
          if (byte_cnt_q == 2'd3) begin
            mem_we_c     = 1'b1;
            mem_wdata_c  = lane_word_c;
            word_addr_d  = word_addr_q + AW'(1);
            word_count_d = word_count_q + WCW'(1);
            byte_cnt_d   = '0;
            word_buf_d   = '0;
          end else begin
            word_buf_d = lane_word_c;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end else if (rx_state_q != RX_IDLE) begin
        idle_cnt_d = '0;
      end else if (got_byte_q) begin
        if (idle_cnt_q == IW'(TIMEOUT - 1)) begin
          // Flush a partial word; untouched upper lanes are still zero
          if (byte_cnt_q != 2'd0) begin
            mem_we_c     = 1'b1;
            word_count_d = word_count_q + WCW'(1);
          end
          ld_state_d = LD_RUN;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset_n) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_state_q   <= RX_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      ld_state_q   <= LD_LOAD;
      byte_cnt_q   <= '0;
      word_addr_q  <= '0;
      word_count_q <= '0;
      word_buf_q   <= '0;
      got_byte_q   <= 1'b0;
      idle_cnt_q   <= '0;
      indication_q <= 1'b0;
    end else begin
      rx_meta_q    <= io_rx;
      rx_s_q       <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      ld_state_q   <= ld_state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_addr_q  <= word_addr_d;
      word_count_q <= word_count_d;
      word_buf_q   <= word_buf_d;
      got_byte_q   <= got_byte_d;
      idle_cnt_q   <= idle_cnt_d;
      indication_q <= indication_d;
    end
  end

  // IMEM: contents survive reset; write suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (mem_we_c && !reset_n) imem_q[mem_waddr_c] <= mem_wdata_c;
    imem_rdata_q <= imem_q[imem_raddr];
  end

  assign indication = indication_q;
  assign imem_rdata = imem_rdata_q;

endmodule

// File: tb/tb_cpu_top.sv
// Directed bench for cpu_top: UART byte frames in, IMEM contents, word_count
// and indication checked against a byte-list model with an idle-timeout rule.
module tb_cpu_top;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int TOB   = 20;
  localparam int T     = TOB * CPB;
  // frame start to byte accepted is ~9.5 bit times, then T idle cycles
  localparam int D     = (19 * CPB) / 2 + T;
  localparam int G     = CPB;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        io_rx;
  logic [1:0]  imem_raddr;
  logic [31:0] imem_rdata;
  logic        indication;

  cpu_top #(
    .CLK_FREQ_HZ      (1_600_000),
    .BAUD             (100_000),
    .IMEM_DEPTH       (DEPTH),
    .IDLE_TIMEOUT_BITS(TOB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .io_rx     (io_rx),
    .imem_raddr(imem_raddr),
    .imem_rdata(imem_rdata),
    .indication(indication)
  );

  always #5 clk = ~clk;

  int         cyc;
  int         chk_cnt;
  int         pass_cnt;
  logic [7:0] m_bytes[$];
  bit         m_have;
  bit         m_busy;
  bit         m_in_rst;
  int         m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // 0 = loading, 1 = running, -1 = inside the timeout uncertainty window
  function automatic int m_phase();
    int d;
    if (!m_have) return 0;
    d = cyc - m_last;
    if (d < D - G) return 0;
    if (d > D + G) return 1;
    return -1;
  endfunction

  function automatic int m_wc(input bit run);
    int n;
    n = m_bytes.size();
    return run ? (n + 3) / 4 : n / 4;
  endfunction

  function automatic logic [31:0] m_word(input int i);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++)
      if (4 * i + j < m_bytes.size()) w[8*j +: 8] = m_bytes[4*i+j];
    return w;
  endfunction

  task automatic cycle_compare();
    int ph;
    if (m_in_rst) return;
    ph = m_phase();
    if (ph >= 0) begin
      check("indication", 32'(indication), 32'(ph));
      if (!m_busy) check("word_count", 32'(dut.word_count_q), 32'(m_wc(ph == 1)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    cycle_compare();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int nstop,
                            input bit accept);
    int  start;
    bit  run_at_start;
    m_busy       = 1'b1;
    start        = cyc;
    run_at_start = (m_phase() == 1);
    io_rx = 1'b0;
    ticks(CPB);
    for (int i = 0; i < 8; i++) begin
      io_rx = b[i];
      ticks(CPB);
    end
    io_rx = stop_val;
    ticks(CPB);
    io_rx = 1'b1;
    ticks((nstop - 1) * CPB);
    if (accept && !run_at_start) begin
      if (m_bytes.size() < 4 * DEPTH) m_bytes.push_back(b);
      m_last = start;
      m_have = 1'b1;
    end
    m_busy = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, 2, 1'b1);
  endtask

  task automatic read_word(input int addr, output logic [31:0] data);
    imem_raddr = 2'(addr);
    tick();
    data = imem_rdata;
  endtask

  task automatic do_reset();
    m_in_rst = 1'b1;
    reset_n  = 1'b1;
    io_rx    = 1'b0;
    tick();
    io_rx    = 1'b1;
    tick();
    reset_n  = 1'b0;
    m_bytes.delete();
    m_have   = 1'b0;
    m_busy   = 1'b0;
    m_in_rst = 1'b0;
  endtask

  task automatic wait_timeout();
    ticks(T + 12 * CPB);
  endtask

  task automatic check_model_words(input string name);
    logic [31:0] w;
    for (int i = 0; i < m_wc(1'b1); i++) begin
      read_word(i, w);
      check(name, w, m_word(i));
    end
  endtask

  logic [31:0] rd;
  logic [7:0]  t3_bytes [9];
  logic [7:0]  t5_bytes [4];

  initial begin
    cyc = 0; chk_cnt = 0; pass_cnt = 0;
    m_in_rst = 1'b1; m_have = 1'b0; m_busy = 1'b0; m_last = 0;
    reset_n = 1'b1; io_rx = 1'b1; imem_raddr = '0;
    t3_bytes = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00, 8'hAA};
    t5_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    // Reset state, and no bytes means LOAD indefinitely
    do_reset();
    check("rst_indication", 32'(indication), 32'd0);
    check("rst_word_count", 32'(dut.word_count_q), 32'd0);
    ticks(T + 4 * CPB);
    check("no_byte_stays_load", 32'(indication), 32'd0);

    // Single word then timeout
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("single_wc", 32'(dut.word_count_q), 32'd1);
    check("single_ind_pre", 32'(indication), 32'd0);
    read_word(0, rd);
    check("single_imem0", rd, 32'h0000_0013);
    wait_timeout();
    check("single_ind", 32'(indication), 32'd1);

    // RUN lock: traffic ignored
    for (int i = 0; i < 4; i++) send_byte(t5_bytes[i]);
    wait_timeout();
    check("run_wc", 32'(dut.word_count_q), 32'd1);
    check("run_ind", 32'(indication), 32'd1);
    read_word(0, rd);
    check("run_imem0", rd, 32'h0000_0013);
    do_reset();
    check("rerst_ind", 32'(indication), 32'd0);

    // Multi-word plus partial
    for (int i = 0; i < 9; i++) send_byte(t3_bytes[i]);
    check("multi_wc_pre", 32'(dut.word_count_q), 32'd2);
    wait_timeout();
    check("multi_wc", 32'(dut.word_count_q), 32'd3);
    check("multi_ind", 32'(indication), 32'd1);
    read_word(0, rd); check("multi_imem0", rd, 32'h0010_0093);
    read_word(1, rd); check("multi_imem1", rd, 32'h0020_0113);
    read_word(2, rd); check("multi_imem2", rd, 32'h0000_00AA);
    check_model_words("multi_model");

    // Glitch and framing error produce no byte
    do_reset();
    io_rx = 1'b0;
    tick();
    io_rx = 1'b1;
    ticks(2 * CPB);
    send_frame(8'h55, 1'b0, 3, 1'b0);
    ticks(T + 4 * CPB);
    check("frm_no_run", 32'(indication), 32'd0);
    send_byte(8'h11);
    wait_timeout();
    check("frm_wc", 32'(dut.word_count_q), 32'd1);
    check("frm_ind", 32'(indication), 32'd1);
    read_word(0, rd); check("frm_imem0", rd, 32'h0000_0011);

    // Overflow: 20 bytes into 4 words
    do_reset();
    for (int i = 0; i < 20; i++) send_byte(8'(i + 1));
    check("ovf_wc_pre", 32'(dut.word_count_q), 32'd4);
    wait_timeout();
    check("ovf_wc", 32'(dut.word_count_q), 32'd4);
    check("ovf_ind", 32'(indication), 32'd1);
    read_word(0, rd); check("ovf_imem0", rd, 32'h0403_0201);
    read_word(3, rd); check("ovf_imem3", rd, 32'h100F_0E0D);
    check_model_words("ovf_model");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
